r2_pair_buffer: RTL
===================

# r2_pair_buffer

Radix-2 delay/commutator stage that sits directly upstream of the complex adder in the FFT datapath. It accepts one complex sample per valid cycle and stores the first N/2 samples of each frame. It pairs each second-half sample x[k+N/2] with the stored x[k] and presents both, registered, as the adder's `a`/`b` operands with a valid strobe and the pair index, which is used for twiddle lookup downstream.

## Interface
- `WL`, 14: signed word length of each real/imag component.
- `N`, 16: frame (FFT) size. Must be a power of two, ≥4. `DEPTH` = N/2 and `LOG2N` = log2(N) are derived.
- `clk` input 1: single clock, all state on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: the sample on `in_r`/`in_i` is accepted this cycle.
- `start` input 1: qualified by `in_valid`; forces the accepted sample to be frame index 0.
- `in_r`, `in_i` input WL: signed input sample.
- `ar`, `ai` output WL: stored first-half sample x[k]; feeds adder `ar`/`ai`.
- `br`, `bi` output WL: current second-half sample x[k+N/2]; feeds adder `br`/`bi`.
- `pair_valid` output 1: `ar`..`bi` hold a new pair this cycle.
- `pair_idx` output LOG2N-1: k of the current pair.
- `frame_done` output 1: the current pair is the last of the frame (k = N/2-1).

## Operation
- Frame counter `cnt` has LOG2N bits. It advances only on accepted samples (`in_valid`=1) and wraps from N-1 to 0.
- Effective index: `idx` = 0 if `start`, else `cnt`. After the sample, `cnt` becomes `idx`+1 mod N.
- Phase is `idx[LOG2N-1]`.
- **Fill (phase 0):** write {`in_r`,`in_i`} to `buf[idx[LOG2N-2:0]]`. No pair is produced.
- **Pair (phase 1):** read `buf[idx low bits]`, then register:
  - `ar`/`ai` ← the stored sample.
  - `br`/`bi` ← the input.
  - `pair_idx` ← idx low bits.
  - `pair_valid` ← 1.
  - `frame_done` ← (idx = N-1).
- No arithmetic is done here. Values pass bit-exact, with no widening or saturation. The adder produces the WL+1 result.
- Cycles with no accepted pair-phase sample:
  - `pair_valid` and `frame_done` go to 0.
  - `ar`..`bi` and `pair_idx` hold their last values.
- `start` mid-frame discards the partial frame:
  - Stored samples are overwritten by the new fill phase.
  - No pair is produced until N/2 new samples have been accepted.
- `start` arriving with `in_valid`=0 is ignored.
- Buffer contents are not reset. This is safe because reset forces the fill phase, which rewrites every read location before it is read.

## Timing
- Latency: 1 cycle from an accepted pair-phase sample to `pair_valid`=1 with that pair on the outputs.
- Throughput: one sample per cycle. `pair_valid` is high for exactly one cycle per accepted second-half sample.
- Back-to-back frames need no bubble. Sample N-1 produces the pair with `frame_done`=1, and the next accepted sample is fill index 0.
- Within the pair phase, read of `buf` is combinational on the same cycle as the input. Fill and pair phases never access the buffer in the same cycle.
- Reset (`reset`=0), applied asynchronously:
  - `cnt`=0.
  - `ar`, `ai`, `br`, `bi`, `pair_idx` = 0.
  - `pair_valid`, `frame_done` = 0.
- Reset asserted mid-pair-phase drops `pair_valid` immediately. After release, the first accepted sample is fill index 0.

## Structure
- Shared package `fft_pkg`:
  - `WL`, `N`, `LOG2N` constants.
  - `cplx_t` typedef: packed {signed re[WL], signed im[WL]}.
- Sub-module `pair_buf_ram`:
  - DEPTH × 2·WL register array.
  - One synchronous write port and one asynchronous read port.
  - No reset.
- Top level holds the counter, phase decode, and output registers.

## Test plan
- **Reset:** hold `reset`=0 with random inputs → all outputs 0, `pair_valid`=0.
- **Continuous frame:** N=16, `in_r`=k, `in_i`=-k for k=0..15 with `in_valid`=1 and `start`=1 at k=0.
  - Eight `pair_valid` pulses with `ar`=0..7, `ai`=0..-7, `br`=8..15, `bi`=-8..-15, `pair_idx`=0..7.
  - `frame_done`=1 only with `pair_idx`=7.
  - Two frames back-to-back repeat this identically.
- **Gapped input:** same data, `in_valid` alternating 1/0 → identical pair sequence. Each `pair_valid` occurs 1 cycle after its accepted sample, never on gap cycles.
- **Extremes:** first half 8191/-8192, second half -8192/8191 → `ar`=8191, `ai`=-8192, `br`=-8192, `bi`=8191, bit-exact.
- **Resync:** `start` with the sample at cnt=11 → no pairs for that sample or the next 7. Pairs resume on the 9th sample after `start`, with `pair_idx`=0 and `ar`=the `start` sample.
- **Mid-operation reset:** assert `reset`=0 during `pair_idx`=4 → `pair_valid` and outputs are 0 immediately. After release, a full frame reproduces the continuous-frame results.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and types.
package fft_pkg;

  localparam int WL    = 14;
  localparam int N     = 16;
  localparam int LOG2N = $clog2(N);

  typedef struct packed {
    logic signed [WL-1:0] re;
    logic signed [WL-1:0] im;
  } cplx_t;

  // Frame phase is the MSB of the frame index.
  typedef enum logic {
    PH_FILL = 1'b0,
    PH_PAIR = 1'b1
  } phase_e;

endpackage

// File: rtl/r2_pair_buffer_ram.sv
// First-half sample store: synchronous write, asynchronous read, no reset.
module pair_buf_ram #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 28
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/r2_pair_buffer.sv
// Radix-2 delay/commutator: pairs x[k+N/2] with stored x[k] for the butterfly adder.
module r2_pair_buffer #(
  parameter int WL = fft_pkg::WL,
  parameter int N  = fft_pkg::N
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       start,
  input  logic signed [WL-1:0]       in_r,
  input  logic signed [WL-1:0]       in_i,
  output logic signed [WL-1:0]       ar,
  output logic signed [WL-1:0]       ai,
  output logic signed [WL-1:0]       br,
  output logic signed [WL-1:0]       bi,
  output logic                       pair_valid,
  output logic [$clog2(N)-2:0]       pair_idx,
  output logic                       frame_done
);
  import fft_pkg::*;

  localparam int LOG2N = $clog2(N);
  localparam int DEPTH = N / 2;
  localparam logic [LOG2N-1:0] ONE = LOG2N'(1);

  logic [LOG2N-1:0] r_cnt;
  logic [LOG2N-1:0] w_idx;
  logic [LOG2N-2:0] w_addr;
  phase_e           w_phase;
  logic             w_we;
  logic [2*WL-1:0]  w_rd;

  assign w_idx   = start ? '0 : r_cnt;
  assign w_addr  = w_idx[LOG2N-2:0];
  assign w_phase = phase_e'(w_idx[LOG2N-1]);
  assign w_we    = in_valid && (w_phase == PH_FILL);

  pair_buf_ram #(
    .DEPTH (DEPTH),
    .AW    (LOG2N-1),
    .W     (2*WL)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_addr),
    .i_wdata ({in_r, in_i}),
    .i_raddr (w_addr),
    .o_rdata (w_rd)
  );

  // Operands and index hold between pairs; only the strobes self-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      ar         <= '0;
      ai         <= '0;
      br         <= '0;
      bi         <= '0;
      pair_idx   <= '0;
      pair_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pair_valid <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        r_cnt <= w_idx + ONE;
        if (w_phase == PH_PAIR) begin
          ar         <= w_rd[2*WL-1:WL];
          ai         <= w_rd[WL-1:0];
          br         <= in_r;
          bi         <= in_i;
          pair_idx   <= w_addr;
          pair_valid <= 1'b1;
          frame_done <= (w_idx == '1);
        end
      end
    end
  end

endmodule
